// File: rtl/rtc_bus_wr.sv
// Write transmitter for the RTC multiplexed address/data bus: captures an address and a
// binary value (saturated to two BCD digits), then runs an address phase and a data phase.
module rtc_bus_wr #(
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_addr,
  input  logic [6:0] i_dat_in,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_cs_n,
  output logic       o_rd_n,
  output logic       o_wr_n,
  output logic       o_ad_sel,
  output logic [7:0] o_ad_out,
  output logic       o_ad_oe
);

  typedef enum logic [2:0] {
    IDLE,
    A_SETUP,
    A_STROBE,
    A_HOLD,
    D_SETUP,
    D_STROBE,
    D_HOLD
  } state_t;

  // Counters load N-1 so that a state lasts exactly N cycles.
  localparam logic [3:0] C_SETUP  = 4'(T_SETUP - 1);
  localparam logic [3:0] C_STROBE = 4'(T_STROBE - 1);
  localparam logic [3:0] C_HOLD   = 4'(T_HOLD - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [7:0] r_data;
  logic       r_busy;
  logic       r_done;
  logic       r_cs_n;
  logic       r_wr_n;
  logic       r_ad_sel;
  logic [7:0] r_ad_out;
  logic       r_ad_oe;

  logic [3:0] w_tens;
  logic [3:0] w_ones;
  logic [7:0] w_bcd;

  // Tens digit found by comparing against each multiple of ten.
  always_comb begin
    w_tens = 4'd0;
    w_ones = 4'(i_dat_in);
    for (int k = 1; k <= 9; k++) begin
      if (i_dat_in >= 7'(10 * k)) begin
        w_tens = 4'(k);
        w_ones = 4'(i_dat_in - 7'(10 * k));
      end
    end
    w_bcd = (i_dat_in > 7'd99) ? 8'h99 : {w_tens, w_ones};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_data   <= 8'h00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cs_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_ad_sel <= 1'b0;
      r_ad_out <= 8'h00;
      r_ad_oe  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (i_start) begin
          r_state  <= A_SETUP;
          r_cnt    <= C_SETUP;
          r_data   <= w_bcd;
          r_busy   <= 1'b1;
          r_cs_n   <= 1'b0;
          r_ad_oe  <= 1'b1;
          r_ad_sel <= 1'b0;
          r_ad_out <= i_addr;
        end
      end else if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        case (r_state)
          A_SETUP: begin
            r_state <= A_STROBE;
            r_cnt   <= C_STROBE;
            r_wr_n  <= 1'b0;
          end
          A_STROBE: begin
            r_state <= A_HOLD;
            r_cnt   <= C_HOLD;
            r_wr_n  <= 1'b1;
          end
          A_HOLD: begin
            r_state  <= D_SETUP;
            r_cnt    <= C_SETUP;
            r_ad_sel <= 1'b1;
            r_ad_out <= r_data;
          end
          D_SETUP: begin
            r_state <= D_STROBE;
            r_cnt   <= C_STROBE;
            r_wr_n  <= 1'b0;
          end
          D_STROBE: begin
            r_state <= D_HOLD;
            r_cnt   <= C_HOLD;
            r_wr_n  <= 1'b1;
          end
          default: begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_cs_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            r_ad_oe  <= 1'b0;
            r_ad_sel <= 1'b0;
            r_ad_out <= 8'h00;
          end
        endcase
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_cs_n   = r_cs_n;
  assign o_rd_n   = 1'b1;
  assign o_wr_n   = r_wr_n;
  assign o_ad_sel = r_ad_sel;
  assign o_ad_out = r_ad_out;
  assign o_ad_oe  = r_ad_oe;

endmodule

// File: tb/tb_rtc_bus_wr.sv
// Drives a default-timing and a 1/1/1-timing instance in lockstep and compares every
// cycle's bus outputs against a per-transaction timeline model.
module tb_rtc_bus_wr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] addr;
  logic [6:0] dat;

  logic       a_busy, a_done, a_cs_n, a_rd_n, a_wr_n, a_ad_sel, a_ad_oe;
  logic [7:0] a_ad_out;
  logic       b_busy, b_done, b_cs_n, b_rd_n, b_wr_n, b_ad_sel, b_ad_oe;
  logic [7:0] b_ad_out;

  always #5 clk = ~clk;

  rtc_bus_wr u_dflt (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_addr(addr), .i_dat_in(dat),
    .o_busy(a_busy), .o_done(a_done), .o_cs_n(a_cs_n), .o_rd_n(a_rd_n),
    .o_wr_n(a_wr_n), .o_ad_sel(a_ad_sel), .o_ad_out(a_ad_out), .o_ad_oe(a_ad_oe)
  );

  rtc_bus_wr #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1)) u_fast (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_addr(addr), .i_dat_in(dat),
    .o_busy(b_busy), .o_done(b_done), .o_cs_n(b_cs_n), .o_rd_n(b_rd_n),
    .o_wr_n(b_wr_n), .o_ad_sel(b_ad_sel), .o_ad_out(b_ad_out), .o_ad_oe(b_ad_oe)
  );

  logic [14:0] obs [2];
  assign obs[0] = {a_busy, a_done, a_cs_n, a_rd_n, a_wr_n, a_ad_sel, a_ad_oe, a_ad_out};
  assign obs[1] = {b_busy, b_done, b_cs_n, b_rd_n, b_wr_n, b_ad_sel, b_ad_oe, b_ad_out};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int S [2] = '{2, 1};
  int W [2] = '{4, 1};
  int H [2] = '{2, 1};

  bit         m_valid [2];
  int         m_tacc  [2];
  logic [7:0] m_addr  [2];
  logic [7:0] m_bcd   [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bcd_of(input int v);
    if (v > 99) return 8'h99;
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int period(input int d);
    return 2 * (S[d] + W[d] + H[d]);
  endfunction

  function automatic bit model_idle(input int d);
    return !m_valid[d] || (cyc - m_tacc[d]) > period(d);
  endfunction

  // Vector order: busy, done, cs_n, rd_n, wr_n, ad_sel, ad_oe, ad_out.
  function automatic logic [14:0] expect_out(input int d);
    int n, p, off;
    logic dph, strobe;
    logic [14:0] v;
    v = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    p = S[d] + W[d] + H[d];
    n = cyc - m_tacc[d];
    if (m_valid[d] && n >= 1 && n <= 2 * p) begin
      off    = (n - 1) % p;
      dph    = (n > p);
      strobe = (off >= S[d]) && (off < S[d] + W[d]);
      v = {1'b1, 1'b0, 1'b0, 1'b1, ~strobe, dph, 1'b1, (dph ? m_bcd[d] : m_addr[d])};
    end else if (m_valid[d] && n == 2 * p + 1) begin
      v[13] = 1'b1;
    end
    return v;
  endfunction

  task automatic step(input bit r, input bit s, input logic [7:0] a, input logic [6:0] v,
                      input string what);
    bit acc [2];
    rst_n = r;
    start = s;
    addr  = a;
    dat   = v;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (!r) m_valid[d] = 1'b0;
      check_eq($sformatf("%s/%s cyc%0d", what, (d == 0) ? "dflt" : "fast", cyc),
               32'(obs[d]), 32'(expect_out(d)));
      acc[d] = r && s && model_idle(d);
    end
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (acc[d]) begin
        m_valid[d] = 1'b1;
        m_tacc[d]  = cyc - 1;
        m_addr[d]  = a;
        m_bcd[d]   = bcd_of(int'(v));
        $display("txn %s cyc %0d addr %h dat %0d bcd %h", (d == 0) ? "dflt" : "fast",
                 cyc, a, v, m_bcd[d]);
      end
    end
    @(negedge clk);
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [6:0] v, input string what);
    step(1'b1, 1'b1, a, v, what);
    repeat (20) step(1'b1, 1'b0, 8'hFF, 7'd127, what);
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    addr  = 8'h00;
    dat   = 7'd0;
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0;
      m_tacc[d]  = 0;
      m_addr[d]  = 8'h00;
      m_bcd[d]   = 8'h00;
    end
    #2 rst_n = 1'b0;
    @(negedge clk);

    repeat (3) step(1'b0, 1'b1, 8'h55, 7'd33, "reset");
    step(1'b1, 1'b0, 8'h00, 7'd0, "idle");

    run_txn(8'h04, 7'd12, "a04_d12");
    run_txn(8'h02, 7'd59, "a02_d59");
    run_txn(8'h31, 7'd120, "sat120");
    run_txn(8'h10, 7'd0, "zero");

    // Second start lands in the default instance's data strobe.
    step(1'b1, 1'b1, 8'h05, 7'd33, "ignore");
    repeat (11) step(1'b1, 1'b0, 8'h00, 7'd0, "ignore");
    step(1'b1, 1'b1, 8'hAA, 7'd77, "ignore");
    repeat (12) step(1'b1, 1'b0, 8'h00, 7'd0, "ignore");

    // Reset lands in the default instance's data strobe.
    step(1'b1, 1'b1, 8'h06, 7'd45, "midrst");
    repeat (11) step(1'b1, 1'b0, 8'h00, 7'd0, "midrst");
    repeat (3) step(1'b0, 1'b0, 8'h00, 7'd0, "midrst");
    repeat (20) step(1'b1, 1'b0, 8'h00, 7'd0, "midrst");
    run_txn(8'h07, 7'd99, "post_rst");

    repeat (70) step(1'b1, 1'b1, 8'($urandom), 7'($urandom), "hold");
    repeat (20) step(1'b1, 1'b0, 8'h00, 7'd0, "hold");

    repeat (600) step($urandom_range(0, 149) != 0, $urandom_range(0, 3) == 0,
                      8'($urandom), 7'($urandom), "rand");
    repeat (20) step(1'b1, 1'b0, 8'h00, 7'd0, "tail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_bus_wr.md
Name: rtc_bus_wr

Overview:
- Transmit side for the time-setting path. Takes a binary value produced by the time-field edit counters (7-bit, 0..99), converts it to packed BCD, and writes it to one RTC register.
- The write uses the RTC's multiplexed address/data parallel bus: an address phase, then a data phase, each with a timed write strobe.
- Sits between the edit counters / control FSM and the RTC pad drivers. Single-shot start/busy/done handshake.

Parameters:
- T_SETUP, 2, cycles ad_out/ad_sel are stable before wr_n falls in each phase (1..15)
- T_STROBE, 4, cycles wr_n is held low in each phase (1..15)
- T_HOLD, 2, cycles ad_out/ad_sel are held after wr_n rises in each phase (1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request a write; sampled only in IDLE
- addr  in  8  RTC register address; captured on accepted start
- dat_in  in  7  binary value to write; captured on accepted start
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse when the transaction has completed
- cs_n  out  1  RTC chip select, active low
- rd_n  out  1  RTC read strobe; constant 1 in this block
- wr_n  out  1  RTC write strobe, active low
- ad_sel  out  1  0 = address phase, 1 = data phase (RTC A/D line)
- ad_out  out  8  multiplexed address/data value
- ad_oe  out  1  bus output enable for the pad tristate

Behaviour:
- Reset (reset=0, asynchronous, effective immediately, including mid-transaction) forces:
  - FSM to IDLE
  - cs_n=1, rd_n=1, wr_n=1, ad_oe=0, ad_sel=0, ad_out=8'h00, busy=0, done=0
  - captured registers cleared
  - No partial strobe survives reset.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- BCD conversion happens at capture:
  - dat_in 0..99: tens digit in [7:4], ones digit in [3:0].
  - dat_in 100..127 saturates to 8'h99.
- FSM states: IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD. A 4-bit down-counter times each state.
- IDLE:
  - start=1 at an edge captures addr and BCD(dat_in) and goes to A_SETUP.
  - Next cycle: busy=1, cs_n=0, ad_oe=1, ad_sel=0, ad_out=addr.
- Timed states:
  - A_SETUP lasts T_SETUP cycles, then A_STROBE.
  - A_STROBE lasts T_STROBE cycles with wr_n=0, then A_HOLD.
  - A_HOLD lasts T_HOLD cycles with wr_n=1, then D_SETUP.
  - D_SETUP / D_STROBE / D_HOLD repeat the same timing with ad_sel=1 and ad_out=BCD data.
  - cs_n and ad_oe stay asserted continuously across both phases.
- After the last D_HOLD cycle the FSM returns to IDLE. In that cycle:
  - cs_n=1, ad_oe=0, wr_n=1, busy=0, done=1 for exactly one cycle.
  - ad_out returns to 00 and ad_sel to 0.
- Latency: the first busy cycle follows the accepting edge. Busy lasts exactly 2*(T_SETUP+T_STROBE+T_HOLD) cycles (16 at defaults). done follows in the next cycle.
- start while busy=1 is ignored, not queued. Captured addr/data do not change mid-transaction.
- start=1 in the done cycle is accepted (FSM is already in IDLE), giving back-to-back transactions with exactly one idle bus cycle (cs_n=1) between them.
- wr_n never falls in the same cycle that ad_out or ad_sel changes. ad_out/ad_sel change only on SETUP entry and on return to IDLE.
- rd_n is never asserted.

Test Plan:
- Reset released, start with addr=8'h04, dat_in=7'd12 → address phase ad_sel=0, ad_out=8'h04 with a 4-cycle wr_n low; data phase ad_sel=1, ad_out=8'h12 with a 4-cycle wr_n low; busy high for 16 cycles; done pulse 1 cycle; cs_n=1 afterwards.
- dat_in=7'd59 with addr=8'h02 → data phase ad_out=8'h59. dat_in=7'd120 → ad_out=8'h99. dat_in=0 → ad_out=8'h00.
- start re-pulsed with a different addr/dat_in during the data strobe → ignored; transaction completes with the originally captured values; only one done pulse.
- reset driven low during D_STROBE → the same cycle shows wr_n=1, cs_n=1, ad_oe=0, busy=0; no done pulse. After release, a new start runs a normal transaction.
- start held high continuously → consecutive transactions with one cs_n=1 cycle between them; done pulses every 17 cycles at default parameters.
- Parameters T_SETUP=1, T_STROBE=1, T_HOLD=1 → busy lasts 6 cycles. Check that the strobe and data edge ordering invariants hold.
